// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with optional skid entry, branch redirect and
// head-entry forwarding. Outputs always present the oldest buffered entry.
//
// state | meaning
// EMPTY | no entries held, mem_valid low
// ONE   | head entry valid
// TWO   | head and skid entries valid, upstream stalled
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_br_cond,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_rd_we,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [4:0]      ex_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_rd_we,
  output logic            mem_mem_rd,
  output logic            mem_mem_wr,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_value
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            rd_we;
    logic            mem_rd;
    logic            mem_wr;
  } entry_t;

  state_t state, state_nxt;
  entry_t head_q, skid_q, in_e;
  logic   accept, drain, taken;
  logic   load_head, load_skid, promote;

  assign in_e = '{pc: ex_pc, result: ex_alu_result, store_data: ex_store_data,
                  rd: ex_rd, rd_we: ex_rd_we, mem_rd: ex_mem_rd, mem_wr: ex_mem_wr};

  // With the skid entry, ready depends only on registered state.
  if (SKID != 0) begin : g_skid
    assign ex_ready = (state != TWO);
  end else begin : g_no_skid
    assign ex_ready = (state == EMPTY) || mem_ready;
  end

  // Handshakes during a redirect cycle are wrong-path: taken and dropped.
  assign accept = ex_valid && ex_ready && !redirect_valid && !flush;
  assign drain  = mem_valid && mem_ready;
  assign taken  = ex_is_jump || (ex_is_branch && ex_br_cond);

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_nxt = ONE;
            promote   = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Entries keep their contents when emptied so payload outputs hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= in_e;
      end else if (promote) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_e;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept && taken;
      if (accept && taken) begin
        redirect_pc <= ex_br_target;
      end
    end
  end

  assign mem_valid      = (state != EMPTY);
  assign mem_pc         = head_q.pc;
  assign mem_result     = head_q.result;
  assign mem_store_data = head_q.store_data;
  assign mem_rd         = head_q.rd;
  assign mem_rd_we      = head_q.rd_we;
  assign mem_mem_rd     = head_q.mem_rd;
  assign mem_mem_wr     = head_q.mem_wr;

  assign fwd_valid = mem_valid && head_q.rd_we && (head_q.rd != 5'd0);
  assign fwd_rd    = head_q.rd;
  assign fwd_value = head_q.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage: a queue model of the buffered instructions
// predicts handshakes, redirects and the MEM/forwarding outputs.
module tb_ex_mem_stage;
  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic            flush = 1'b0;
  logic            ex_valid = 1'b0;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc = '0, ex_alu_result = '0, ex_br_target = '0, ex_store_data = '0;
  logic            ex_br_cond = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
  logic            ex_rd_we = 1'b0, ex_mem_rd = 1'b0, ex_mem_wr = 1'b0;
  logic [4:0]      ex_rd = '0;
  logic            mem_valid;
  logic            mem_ready = 1'b0;
  logic [XLEN-1:0] mem_pc, mem_result, mem_store_data;
  logic [4:0]      mem_rd;
  logic            mem_rd_we, mem_mem_rd, mem_mem_wr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_value;

  ex_mem_stage #(.XLEN(XLEN), .SKID(1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_br_target(ex_br_target),
    .ex_store_data(ex_store_data), .ex_br_cond(ex_br_cond), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_rd_we(ex_rd_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_pc(mem_pc), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_value(fwd_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            rd_we;
    logic            mem_rd;
    logic            mem_wr;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_h;
  exp_t            new_e;
  logic            exp_ready = 1'b1;
  logic            exp_redirect = 1'b0;
  logic [XLEN-1:0] exp_redirect_pc = '0;
  logic            model_on = 1'b0;
  logic            acc;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: mid-cycle, compare handshake/outputs with the model and retire the head.
  initial forever begin
    @(negedge clock);
    if (reset_n && model_on) begin
      exp_ready = (exp_q.size() < 2);
      check("ex_ready", ex_ready, exp_ready);
      check("mem_valid", mem_valid, exp_q.size() != 0);
      check("redirect_valid", redirect_valid, exp_redirect);
      if (exp_redirect) check("redirect_pc", redirect_pc, exp_redirect_pc);
      if (!mem_valid) check("fwd_idle", fwd_valid, 1'b0);
      if (mem_valid && exp_q.size() != 0) begin
        mon_h = exp_q[0];
        check("head", {mem_pc, mem_result, mem_store_data, mem_rd, mem_rd_we, mem_mem_rd, mem_mem_wr},
              {mon_h.pc, mon_h.result, mon_h.store_data, mon_h.rd, mon_h.rd_we, mon_h.mem_rd, mon_h.mem_wr});
        check("fwd", {fwd_valid, fwd_rd, fwd_value},
              {mon_h.rd_we && (mon_h.rd != 5'd0), mon_h.rd, mon_h.result});
        if (mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Model: at each edge, apply flush or record the accepted, non-wrong-path instruction.
  initial forever begin
    @(posedge clock);
    if (reset_n && model_on) begin
      if (flush) begin
        exp_q.delete();
        exp_redirect = 1'b0;
      end else begin
        acc = ex_valid && exp_ready && !exp_redirect;
        if (acc) begin
          new_e.pc = ex_pc;
          new_e.result = ex_alu_result;
          new_e.store_data = ex_store_data;
          new_e.rd = ex_rd;
          new_e.rd_we = ex_rd_we;
          new_e.mem_rd = ex_mem_rd;
          new_e.mem_wr = ex_mem_wr;
          exp_q.push_back(new_e);
        end
        exp_redirect = acc && (ex_is_jump || (ex_is_branch && ex_br_cond));
        if (exp_redirect) exp_redirect_pc = ex_br_target;
      end
    end
  end

  // Phase table: percent valid, ready, flush, control-transfer.
  int pv[5] = '{100, 100, 85, 85, 70};
  int pr[5] = '{100, 25, 70, 50, 60};
  int pf[5] = '{0, 0, 0, 8, 3};
  int pb[5] = '{0, 0, 40, 30, 30};

  task automatic drive(input int p);
    logic br;
    ex_valid      = ($urandom_range(99) < pv[p]);
    mem_ready     = ($urandom_range(99) < pr[p]);
    flush         = ($urandom_range(99) < pf[p]);
    br            = ($urandom_range(99) < pb[p]);
    ex_is_branch  = br && $urandom_range(1) == 1;
    ex_is_jump    = br && !ex_is_branch;
    ex_br_cond    = $urandom_range(1) == 1;
    ex_pc         = $urandom;
    ex_alu_result = $urandom;
    ex_br_target  = $urandom;
    ex_store_data = $urandom;
    ex_rd         = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
    ex_rd_we      = $urandom_range(1) == 1;
    ex_mem_rd     = $urandom_range(1) == 1;
    ex_mem_wr     = $urandom_range(1) == 1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_mem_valid"}, mem_valid, 1'b0);
    check({tag, "_redirect"}, redirect_valid, 1'b0);
    check({tag, "_fwd_valid"}, fwd_valid, 1'b0);
    check({tag, "_ex_ready"}, ex_ready, 1'b1);
    check({tag, "_payload"}, {mem_pc, mem_result, mem_rd}, '0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 reset_checks("rst_init");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    model_on = 1'b1;
    for (int p = 0; p < 5; p++) begin
      repeat (400) begin
        drive(p);
        @(posedge clock);
        #1;
      end
      if (p == 2) begin
        #2 reset_n = 1'b0;
        #1 reset_checks("rst_mid");
        exp_q.delete();
        exp_redirect = 1'b0;
        exp_ready = 1'b1;
        ex_valid = 1'b0;
        flush = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
      end
    end
    ex_valid = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1 check("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
